// File: rtl/niu_sii_req_tx.sv
// niu_sii_req_tx
// Turns client DMA requests into SII header/payload cycles.
// A read issues one header cycle. A write first collects four 128-bit payload
// beats, then issues one header cycle followed by the four beats.
// A header is sent only when the target queue (ordered or bypass) has a credit.
// Ports:
//   iol2clk, rst_l                 - clock, synchronous active-low reset
//   req_vld/req_rdy, req_wr,
//   req_bypass, req_hdr            - request handshake and header
//   dat_vld/dat_rdy, dat, dat_be   - write payload beat handshake
//   sii_niu_oqdq, sii_niu_bqdq     - credit return pulses
//   niu_sii_*                      - registered SII request outputs
//   credit_err                     - sticky credit-overflow flag
module niu_sii_req_tx #(
  parameter int unsigned OQ_CREDITS = 16,
  parameter int unsigned BQ_CREDITS = 16
) (
  input  logic         iol2clk,
  input  logic         rst_l,
  input  logic         req_vld,
  output logic         req_rdy,
  input  logic         req_wr,
  input  logic         req_bypass,
  input  logic [127:0] req_hdr,
  input  logic         dat_vld,
  output logic         dat_rdy,
  input  logic [127:0] dat,
  input  logic [15:0]  dat_be,
  input  logic         sii_niu_oqdq,
  input  logic         sii_niu_bqdq,
  output logic         niu_sii_hdr_vld,
  output logic         niu_sii_reqbypass,
  output logic         niu_sii_datareq,
  output logic         niu_sii_datareq16,
  output logic [127:0] niu_sii_data,
  output logic [7:0]   niu_sii_parity,
  output logic [15:0]  niu_sii_be,
  output logic         credit_err
);

  localparam int unsigned OQ_W = $clog2(OQ_CREDITS + 1);
  localparam int unsigned BQ_W = $clog2(BQ_CREDITS + 1);
  localparam logic [OQ_W-1:0] OQ_MAX = OQ_W'(OQ_CREDITS);
  localparam logic [BQ_W-1:0] BQ_MAX = BQ_W'(BQ_CREDITS);
  localparam logic [OQ_W-1:0] OQ_ONE = OQ_W'(1);
  localparam logic [BQ_W-1:0] BQ_ONE = BQ_W'(1);

  typedef enum logic [2:0] {IDLE, LOAD, CRED, HDR, PAY} state_t;

  state_t         state, next_state;
  logic [127:0]   hdr_q;
  logic           wr_q, byp_q;
  logic [1:0]     beat_cnt;
  logic [127:0]   beat_buf [4];
  logic [15:0]    be_buf [4];
  logic [OQ_W-1:0] oq_cnt;
  logic [BQ_W-1:0] bq_cnt;
  logic           oq_dec, bq_dec;
  logic [1:0]     pay_idx;
  logic           hdr_d, byp_d, dreq_d;
  logic [127:0]   data_d;
  logic [15:0]    be_d;
  logic [7:0]     par_d;

  assign req_rdy           = rst_l && (state == IDLE);
  assign dat_rdy           = rst_l && (state == LOAD);
  assign niu_sii_datareq16 = 1'b0;

  always_ff @(posedge iol2clk) begin
    if (!rst_l) state <= IDLE;
    else        state <= next_state;
  end

  // Outputs are computed for the state being entered so that they can be
  // registered and still line up with that state.
  always_comb begin
    next_state = state;
    oq_dec     = 1'b0;
    bq_dec     = 1'b0;
    pay_idx    = 2'd0;
    hdr_d      = 1'b0;
    byp_d      = 1'b0;
    dreq_d     = 1'b0;
    data_d     = '0;
    be_d       = '0;
    case (state)
      IDLE: if (req_vld) next_state = req_wr ? LOAD : CRED;
      LOAD: if (dat_vld && beat_cnt == 2'd3) next_state = CRED;
      CRED: begin
        if (byp_q) begin
          if (bq_cnt != '0) begin
            next_state = HDR;
            bq_dec     = 1'b1;
          end
        end else if (oq_cnt != '0) begin
          next_state = HDR;
          oq_dec     = 1'b1;
        end
      end
      HDR: next_state = wr_q ? PAY : IDLE;
      PAY: begin
        // beat_cnt is the beat on the bus now; the next one is loaded.
        pay_idx = beat_cnt + 2'd1;
        if (beat_cnt == 2'd3) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    case (next_state)
      HDR: begin
        hdr_d  = 1'b1;
        data_d = hdr_q;
        byp_d  = byp_q;
        dreq_d = wr_q;
      end
      PAY: begin
        data_d = beat_buf[pay_idx];
        be_d   = be_buf[pay_idx];
      end
      default: ;
    endcase
    par_d = {^data_d[127:112], ^data_d[111:96], ^data_d[95:80], ^data_d[79:64],
             ^data_d[63:48],   ^data_d[47:32],  ^data_d[31:16], ^data_d[15:0]};
  end

  always_ff @(posedge iol2clk) begin
    if (!rst_l) begin
      hdr_q <= '0;
      wr_q  <= 1'b0;
      byp_q <= 1'b0;
    end else if (state == IDLE && req_vld) begin
      hdr_q <= req_hdr;
      wr_q  <= req_wr;
      byp_q <= req_bypass;
    end
  end

  // The beat counter fills the buffer in LOAD, wraps to 0, then walks the
  // buffer again in PAY.
  always_ff @(posedge iol2clk) begin
    if (!rst_l) begin
      beat_cnt <= 2'd0;
      beat_buf <= '{default: '0};
      be_buf   <= '{default: '0};
    end else if (state == LOAD && dat_vld) begin
      beat_buf[beat_cnt] <= dat;
      be_buf[beat_cnt]   <= dat_be;
      beat_cnt           <= beat_cnt + 2'd1;
    end else if (state == PAY) begin
      beat_cnt <= beat_cnt + 2'd1;
    end
  end

  always_ff @(posedge iol2clk) begin
    if (!rst_l) begin
      oq_cnt     <= OQ_MAX;
      bq_cnt     <= BQ_MAX;
      credit_err <= 1'b0;
    end else begin
      if (sii_niu_oqdq && !oq_dec) begin
        if (oq_cnt == OQ_MAX) credit_err <= 1'b1;
        else                  oq_cnt     <= oq_cnt + OQ_ONE;
      end else if (oq_dec && !sii_niu_oqdq) begin
        oq_cnt <= oq_cnt - OQ_ONE;
      end
      if (sii_niu_bqdq && !bq_dec) begin
        if (bq_cnt == BQ_MAX) credit_err <= 1'b1;
        else                  bq_cnt     <= bq_cnt + BQ_ONE;
      end else if (bq_dec && !sii_niu_bqdq) begin
        bq_cnt <= bq_cnt - BQ_ONE;
      end
    end
  end

  always_ff @(posedge iol2clk) begin
    if (!rst_l) begin
      niu_sii_hdr_vld   <= 1'b0;
      niu_sii_reqbypass <= 1'b0;
      niu_sii_datareq   <= 1'b0;
      niu_sii_data      <= '0;
      niu_sii_parity    <= '0;
      niu_sii_be        <= '0;
    end else begin
      niu_sii_hdr_vld   <= hdr_d;
      niu_sii_reqbypass <= byp_d;
      niu_sii_datareq   <= dreq_d;
      niu_sii_data      <= data_d;
      niu_sii_parity    <= par_d;
      niu_sii_be        <= be_d;
    end
  end

endmodule

// File: tb/tb_niu_sii_req_tx.sv
// Self-checking bench for niu_sii_req_tx: random transactions checked against
// a transaction-level model of header/payload ordering and per-queue credits.
module tb_niu_sii_req_tx;

  localparam int OQ_MAX = 16;
  localparam int BQ_MAX = 16;

  logic         iol2clk = 1'b0;
  logic         rst_l;
  logic         req_vld, req_rdy, req_wr, req_bypass;
  logic [127:0] req_hdr;
  logic         dat_vld, dat_rdy;
  logic [127:0] dat;
  logic [15:0]  dat_be;
  logic         sii_niu_oqdq, sii_niu_bqdq;
  logic         niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16;
  logic [127:0] niu_sii_data;
  logic [7:0]   niu_sii_parity;
  logic [15:0]  niu_sii_be;
  logic         credit_err;

  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  int           m_oq, m_bq;
  bit           m_err;
  int unsigned  ret_pct;
  logic [127:0] tx_dat [4];
  logic [15:0]  tx_be [4];

  niu_sii_req_tx #(.OQ_CREDITS(OQ_MAX), .BQ_CREDITS(BQ_MAX)) dut (
    .iol2clk(iol2clk), .rst_l(rst_l),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_bypass(req_bypass), .req_hdr(req_hdr),
    .dat_vld(dat_vld), .dat_rdy(dat_rdy), .dat(dat), .dat_be(dat_be),
    .sii_niu_oqdq(sii_niu_oqdq), .sii_niu_bqdq(sii_niu_bqdq),
    .niu_sii_hdr_vld(niu_sii_hdr_vld), .niu_sii_reqbypass(niu_sii_reqbypass),
    .niu_sii_datareq(niu_sii_datareq), .niu_sii_datareq16(niu_sii_datareq16),
    .niu_sii_data(niu_sii_data), .niu_sii_parity(niu_sii_parity),
    .niu_sii_be(niu_sii_be), .credit_err(credit_err)
  );

  always #5 iol2clk = ~iol2clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [7:0] parity_of(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

  // Credit rule: return alone adds one (saturating with error at max),
  // consume alone subtracts one, both together cancel.
  task automatic credit_step(inout int c, input bit ret, input bit dec, input int mx);
    if (ret && !dec) begin
      if (c == mx) m_err = 1'b1;
      else         c++;
    end else if (dec && !ret) begin
      c--;
    end
  endtask

  task automatic clk_edge(input bit dec_oq, input bit dec_bq, input bit frc_oq, input bit frc_bq);
    bit r_oq, r_bq, in_rst;
    r_oq = frc_oq || ($urandom_range(0, 99) < ret_pct);
    r_bq = frc_bq || ($urandom_range(0, 99) < ret_pct);
    sii_niu_oqdq = r_oq;
    sii_niu_bqdq = r_bq;
    in_rst = !rst_l;
    @(posedge iol2clk);
    #1;
    sii_niu_oqdq = 1'b0;
    sii_niu_bqdq = 1'b0;
    if (in_rst) begin
      m_oq  = OQ_MAX;
      m_bq  = BQ_MAX;
      m_err = 1'b0;
    end else begin
      credit_step(m_oq, r_oq, dec_oq, OQ_MAX);
      credit_step(m_bq, r_bq, dec_bq, BQ_MAX);
    end
    check("parity", 160'(niu_sii_parity), 160'(parity_of(niu_sii_data)));
    check("datareq16", 160'(niu_sii_datareq16), 160'(1'b0));
    check("credit_err", 160'(credit_err), 160'(m_err));
  endtask

  task automatic check_quiet(input string tag);
    check(tag, 160'({niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq,
                     niu_sii_be, niu_sii_parity, niu_sii_data}), 160'(0));
  endtask

  // One request from IDLE back to IDLE. abort_beat >= 0 applies reset while
  // that payload beat is on the bus.
  task automatic do_txn(input bit wr, input bit byp, input logic [127:0] hdr,
                        input bit hdr_ret, input int abort_beat);
    int stall;
    check("idle_rdy", 160'(req_rdy), 160'(1'b1));
    req_vld = 1'b1; req_wr = wr; req_bypass = byp; req_hdr = hdr;
    clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
    req_vld = 1'b0; req_hdr = rand128();
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          dat_vld = 1'b0;
          check("load_rdy", 160'(dat_rdy), 160'(1'b1));
          check_quiet("load_quiet");
          clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
        end
        dat_vld = 1'b1; dat = tx_dat[b]; dat_be = tx_be[b];
        check("load_rdy", 160'(dat_rdy), 160'(1'b1));
        clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
      end
      dat_vld = 1'b0; dat = rand128();
    end
    stall = 0;
    while ((byp ? m_bq : m_oq) == 0 && stall < 20) begin
      check_quiet("cred_wait_quiet");
      check("cred_wait_rdy", 160'(req_rdy), 160'(1'b0));
      clk_edge(1'b0, 1'b0, !byp && stall >= 2, byp && stall >= 2);
      stall++;
    end
    clk_edge(!byp, byp, hdr_ret && !byp, hdr_ret && byp);
    check("hdr_vld", 160'(niu_sii_hdr_vld), 160'(1'b1));
    check("hdr_data", 160'(niu_sii_data), 160'(hdr));
    check("hdr_bypass", 160'(niu_sii_reqbypass), 160'(byp));
    check("hdr_datareq", 160'(niu_sii_datareq), 160'(wr));
    check("hdr_be", 160'(niu_sii_be), 160'(0));
    check("hdr_rdy", 160'(req_rdy), 160'(1'b0));
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
        check("pay_data", 160'(niu_sii_data), 160'(tx_dat[b]));
        check("pay_be", 160'(niu_sii_be), 160'(tx_be[b]));
        check("pay_ctl", 160'({niu_sii_hdr_vld, niu_sii_datareq}), 160'(0));
        if (b == abort_beat) begin
          rst_l = 1'b0;
          clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
          check_quiet("abort_quiet");
          check("abort_rdy", 160'(req_rdy), 160'(1'b0));
          rst_l = 1'b1;
          #1;
          check("abort_rel_rdy", 160'(req_rdy), 160'(1'b1));
          repeat (5) begin
            clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
            check_quiet("abort_after");
            check("abort_idle_rdy", 160'(req_rdy), 160'(1'b1));
          end
          return;
        end
      end
    end
    clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
    check_quiet("end_quiet");
    check("end_rdy", 160'(req_rdy), 160'(1'b1));
  endtask

  task automatic rand_txn();
    bit wr, byp;
    int idle;
    wr  = 1'($urandom_range(0, 1));
    byp = 1'($urandom_range(0, 1));
    for (int b = 0; b < 4; b++) begin
      tx_dat[b] = rand128();
      tx_be[b]  = 16'($urandom());
    end
    idle = int'($urandom_range(0, 2));
    for (int i = 0; i < idle; i++) begin
      check_quiet("idle_quiet");
      clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
    end
    do_txn(wr, byp, rand128(), 1'b0, -1);
  endtask

  initial begin
    rst_l = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_bypass = 1'b0; req_hdr = '0;
    dat_vld = 1'b0; dat = '0; dat_be = '0; sii_niu_oqdq = 1'b0; sii_niu_bqdq = 1'b0;
    ret_pct = 0; m_oq = OQ_MAX; m_bq = BQ_MAX; m_err = 1'b0;

    repeat (2) clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
    check_quiet("rst_outputs");
    check("rst_req_rdy", 160'(req_rdy), 160'(1'b0));
    check("rst_dat_rdy", 160'(dat_rdy), 160'(1'b0));
    rst_l = 1'b1;
    #1;
    check("rel_req_rdy", 160'(req_rdy), 160'(1'b1));

    // Ordered read of header 1, then bypass write of A0..A3.
    do_txn(1'b0, 1'b0, 128'h1, 1'b0, -1);
    for (int b = 0; b < 4; b++) begin
      tx_dat[b] = 128'hA0 + 128'(b);
      tx_be[b]  = 16'hFFFF;
    end
    do_txn(1'b1, 1'b1, rand128(), 1'b0, -1);

    ret_pct = 25;
    repeat (30) rand_txn();
    ret_pct = 0;

    // Write aborted by reset during its second payload beat.
    for (int b = 0; b < 4; b++) begin
      tx_dat[b] = rand128();
      tx_be[b]  = 16'($urandom());
    end
    do_txn(1'b1, 1'b0, rand128(), 1'b0, 1);

    // Exhaust the ordered credits; the 17th read must wait for a return.
    repeat (16) do_txn(1'b0, 1'b0, rand128(), 1'b0, -1);
    do_txn(1'b0, 1'b0, rand128(), 1'b0, -1);
    // Return coincides with the consuming transition at count 1.
    do_txn(1'b0, 1'b0, rand128(), 1'b1, -1);
    do_txn(1'b0, 1'b0, rand128(), 1'b0, -1);
    do_txn(1'b0, 1'b0, rand128(), 1'b0, -1);
    do_txn(1'b0, 1'b1, rand128(), 1'b0, -1);

    // Overflow: return at full count sets the sticky error.
    rst_l = 1'b0;
    clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
    rst_l = 1'b1;
    clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
    clk_edge(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
    rst_l = 1'b0;
    clk_edge(1'b0, 1'b0, 1'b0, 1'b0);
    rst_l = 1'b1;
    clk_edge(1'b0, 1'b0, 1'b0, 1'b1);
    check_quiet("sat_quiet");

    ret_pct = 10;
    repeat (20) rand_txn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/niu_sii_req_tx.md
NIU_SII_REQ_TX -- requirements
Module: niu_sii_req_tx

Interface
REQ-001: Parameter OQ_CREDITS, default 16, ordered-queue header credits available out of reset.
REQ-002: Parameter BQ_CREDITS, default 16, bypass-queue header credits available out of reset.
REQ-003: The block SHALL have one clock and a synchronous, active-low reset; all ports are listed below.
- iol2clk, in, 1: sole clock; all state updates on its rising edge.
- rst_l, in, 1: synchronous active-low reset.
- req_vld / req_rdy, in / out, 1 / 1: client request handshake; transfer when both are 1.
- req_wr, in, 1: 1 = DMA write, 0 = DMA read.
- req_bypass, in, 1: 1 = bypass queue, 0 = ordered queue.
- req_hdr, in, 128: header bits.
- dat_vld / dat_rdy, in / out, 1 / 1: write payload beat handshake.
- dat, in, 128: payload beat.
- dat_be, in, 16: byte enables for the beat.
- sii_niu_oqdq, in, 1: one-cycle pulse returning one ordered-queue credit.
- sii_niu_bqdq, in, 1: one-cycle pulse returning one bypass-queue credit.
- niu_sii_hdr_vld, out, 1: header cycle.
- niu_sii_reqbypass, out, 1: header targets the bypass queue.
- niu_sii_datareq, out, 1: header is a write with 64B payload.
- niu_sii_datareq16, out, 1: tied to 0.
- niu_sii_data, out, 128: header or payload.
- niu_sii_parity, out, 8: parity over niu_sii_data.
- niu_sii_be, out, 16: payload byte enables.
- credit_err, out, 1: sticky credit-overflow flag.

Function
REQ-004: FSM states SHALL be IDLE, LOAD, CRED, HDR and PAY.
REQ-005: IDLE SHALL drive req_rdy=1; on accept it latches hdr/wr/bypass and goes to LOAD if req_wr=1, otherwise to CRED.
REQ-006: LOAD SHALL drive dat_rdy=1 and store accepted beats 0..3 with dat_be in a 4-entry buffer; after the 4th accept it goes to CRED.
- Beat count SHALL be a 2-bit counter; no back-pressure other than dat_vld.
REQ-007: CRED SHALL go to HDR when the selected credit counter is nonzero, otherwise remain.
- That counter decrements by 1 on the CRED->HDR transition.
REQ-008: HDR lasts exactly one cycle and SHALL drive:
- niu_sii_hdr_vld=1;
- niu_sii_data=latched header;
- niu_sii_reqbypass=latched bypass;
- niu_sii_datareq=latched wr;
- niu_sii_be=0.
- Next state is PAY for a write, IDLE for a read.
REQ-009: PAY SHALL drive buffered beats 0,1,2,3 with their byte enables on 4 consecutive cycles immediately after HDR, with hdr_vld=0 and datareq=0, then go to IDLE.
REQ-010: Outside HDR/PAY, niu_sii_data, niu_sii_parity, niu_sii_be, hdr_vld, reqbypass and datareq SHALL be 0.
REQ-011: All niu_sii_* outputs SHALL be driven from flops.
REQ-012: niu_sii_parity[i] SHALL equal the even parity (XOR) of niu_sii_data[16i+15:16i] in the same cycle, for i=0..7.
REQ-013: Credit counter updates, per queue:
- Return pulse only: +1.
- Return pulse and decrement in the same cycle: unchanged.
- Return at the maximum (OQ_CREDITS/BQ_CREDITS) with no decrement: holds at the maximum and sets credit_err=1 until reset.
REQ-014: Counters SHALL be ceil(log2(max+1)) bits wide and never wrap below 0.
REQ-015: Minimum spacing between header cycles SHALL be:
- read to next header: 3 cycles;
- write to next header: 7 cycles plus payload load time.
- The block SHALL NOT issue back-to-back headers.

Reset
REQ-016: While rst_l=0 at a clock edge, the block SHALL:
- enter IDLE;
- drive all outputs to 0 (req_rdy included);
- clear the beat buffer and counter;
- restore credit counters to OQ_CREDITS/BQ_CREDITS;
- clear credit_err;
- ignore return pulses.
REQ-017: Reset asserted in any state, including mid-PAY, SHALL abort the transfer with no further payload beats; req_rdy=1 on the first cycle after rst_l rises.

Verification
REQ-018: Read, ordered queue, req_hdr=128'h1 -> 2 cycles after accept: hdr_vld=1, datareq=0, reqbypass=0, data=128'h1, parity=8'h01; OQ credit 16->15.
REQ-019: Write, bypass queue, beats 128'hA0..A3, be=16'hFFFF -> hdr_vld=1, datareq=1, reqbypass=1 for one cycle, then data A0,A1,A2,A3 on 4 consecutive cycles with be=FFFF; BQ credit 16->15.
REQ-020: 16 ordered reads with no oqdq -> 16 headers issued; the 17th stays in CRED; one oqdq pulse -> header 2 cycles later.
REQ-021: oqdq pulse in the same cycle as CRED->HDR with counter=1 -> counter stays 1; oqdq with counter=16 -> counter 16, credit_err=1.
REQ-022: rst_l=0 during the 2nd PAY beat -> next cycle all niu_sii_* are 0, no further beats, credits=16/16, req_rdy=1 after release.
REQ-023: Random header/data -> parity checked against REQ-012 on every HDR/PAY cycle; datareq16 always 0.
